// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential increment, stall, redirects,
// and a circular return-address stack for call/return.
module pc_unit #(
    parameter int          PC_W         = 16,
    parameter int          PC_INC       = 4,
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter int          RAS_DEPTH    = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           stall_i,
    input  logic                           branch_taken_i,
    input  logic [PC_W-1:0]                branch_target_i,
    input  logic                           jump_i,
    input  logic [PC_W-1:0]                jump_target_i,
    input  logic                           call_i,
    input  logic                           ret_i,
    output logic [PC_W-1:0]                pc_value_o,
    output logic [PC_W-1:0]                pc_next_o,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count_o,
    output logic                           ras_empty_o,
    output logic                           ras_full_o,
    output logic                           ras_overflow_o,
    output logic                           ras_underflow_o
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PC_W-1:0]  INC     = PC_W'(PC_INC);
    localparam logic [PC_W-1:0]  RST_PC  = PC_W'(RESET_VECTOR);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);
    localparam logic [PTR_W-1:0] LAST    = PTR_W'(RAS_DEPTH - 1);

    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_seq;
    logic [PC_W-1:0]  pc_next;
    logic [PC_W-1:0]  ras_top;
    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             ovf_set;
    logic             unf_set;
    logic             ovf;
    logic             unf;

    // wr_ptr names the next free slot; the top of stack sits just below it
    assign pc_seq  = pc_q + INC;
    assign ptr_inc = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
    assign ptr_dec = (wr_ptr == '0) ? LAST : wr_ptr - 1'b1;
    assign ras_top = ras_mem[ptr_dec];

    always_comb begin
        pc_next = pc_seq;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (rst_i) begin
            pc_next = RST_PC;
        end else if (stall_i) begin
            pc_next = pc_q;
        end else if (ret_i) begin
            if (count != '0) begin
                pc_next = ras_top;
                pop     = 1'b1;
            end else begin
                unf_set = 1'b1;
            end
        end else if (jump_i) begin
            pc_next = jump_target_i;
            push    = call_i;
            ovf_set = call_i && (count == DEPTH_C);
        end else if (branch_taken_i) begin
            pc_next = branch_target_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q   <= RST_PC;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            pc_q <= pc_next;
            if (push) begin
                wr_ptr <= ptr_inc;
                if (count != DEPTH_C) begin
                    count <= count + 1'b1;
                end
            end else if (pop) begin
                wr_ptr <= ptr_dec;
                count  <= count - 1'b1;
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end
            if (unf_set) begin
                unf <= 1'b1;
            end
        end
    end

    // A push when full lands on the oldest slot, overwriting it
    always_ff @(posedge clk_i) begin
        if (push) begin
            ras_mem[wr_ptr] <= pc_seq;
        end
    end

    assign pc_value_o      = pc_q;
    assign pc_next_o       = pc_next;
    assign ras_count_o     = count;
    assign ras_empty_o     = (count == '0);
    assign ras_full_o      = (count == DEPTH_C);
    assign ras_overflow_o  = ovf;
    assign ras_underflow_o = unf;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios then random traffic, checked
// against a queue-based model of the PC and return stack.
module tb_pc_unit;

    localparam logic [15:0] RV = 16'h0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [15:0] bt = '0;
    logic        jmp = 1'b0;
    logic [15:0] jt = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [15:0] pc_value;
    logic [15:0] pc_next;
    logic [2:0]  ras_count;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_ovf;
    logic        ras_unf;

    int compared = 0;
    int mismatched = 0;

    logic [15:0] m_pc;
    logic [15:0] m_ras[$];
    logic        m_ovf;
    logic        m_unf;

    pc_unit #(
        .PC_W(16),
        .PC_INC(4),
        .RESET_VECTOR(RV),
        .RAS_DEPTH(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .stall_i(stall),
        .branch_taken_i(br),
        .branch_target_i(bt),
        .jump_i(jmp),
        .jump_target_i(jt),
        .call_i(call),
        .ret_i(ret),
        .pc_value_o(pc_value),
        .pc_next_o(pc_next),
        .ras_count_o(ras_count),
        .ras_empty_o(ras_empty),
        .ras_full_o(ras_full),
        .ras_overflow_o(ras_ovf),
        .ras_underflow_o(ras_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_next();
        if (rst) return RV;
        if (stall) return m_pc;
        if (ret) return (m_ras.size() > 0) ? m_ras[$] : 16'(m_pc + 16'd4);
        if (jmp) return jt;
        if (br) return bt;
        return 16'(m_pc + 16'd4);
    endfunction

    task automatic model_edge();
        logic [15:0] nxt;
        logic [15:0] ra;
        nxt = model_next();
        ra  = 16'(m_pc + 16'd4);
        if (rst) begin
            m_ras.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (!stall) begin
            if (ret) begin
                if (m_ras.size() > 0) void'(m_ras.pop_back());
                else m_unf = 1'b1;
            end else if (jmp && call) begin
                if (m_ras.size() == 4) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
                m_ras.push_back(ra);
            end
        end
        m_pc = nxt;
    endtask

    // Apply one cycle of inputs, check the prefetch value, clock, check state
    task automatic step(input logic i_rst, input logic i_stall,
                        input logic i_br, input logic [15:0] i_bt,
                        input logic i_jmp, input logic [15:0] i_jt,
                        input logic i_call, input logic i_ret);
        rst = i_rst;
        stall = i_stall;
        br = i_br;
        bt = i_bt;
        jmp = i_jmp;
        jt = i_jt;
        call = i_call;
        ret = i_ret;
        #1;
        chk("pc_next", 32'(pc_next), 32'(model_next()));
        @(posedge clk);
        model_edge();
        #1;
        chk("pc_value", 32'(pc_value), 32'(m_pc));
        chk("ras_count", 32'(ras_count), 32'(m_ras.size()));
        chk("ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
        chk("ras_full", 32'(ras_full), 32'(m_ras.size() == 4));
        chk("overflow", 32'(ras_ovf), 32'(m_ovf));
        chk("underflow", 32'(ras_unf), 32'(m_unf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_pc = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #1;
        // reset then sequential fetch
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_pc", 32'(pc_value), 32'h0100);
        idle(3);
        chk("seq_pc", 32'(pc_value), 32'h010C);
        // wrap then stall with a pending jump
        step(0, 0, 0, 0, 1, 16'hFFF8, 0, 0);
        idle(2);
        chk("wrap_pc", 32'(pc_value), 32'h0000);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 16'h1234, 1, 0);
        chk("stall_pc", 32'(pc_value), 32'h0000);
        // priority: ret on empty stack beats jump and branch
        step(0, 0, 0, 0, 1, 16'h0200, 0, 0);
        step(0, 0, 1, 16'h0300, 1, 16'h0400, 0, 1);
        chk("prio_ret_empty", 32'(pc_value), 32'h0204);
        step(0, 0, 1, 16'h0300, 1, 16'h0400, 0, 0);
        chk("prio_jump", 32'(pc_value), 32'h0400);
        // call and return
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 16'h0500, 1, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("ret_pc", 32'(pc_value), 32'h0104);
        // overflow with 5 nested calls then 5 returns
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 16'h0010, 0, 0);
        for (int i = 2; i <= 6; i++) step(0, 0, 0, 0, 1, 16'(i * 16), 1, 0);
        chk("ovf_flag", 32'(ras_ovf), 32'h1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("ret_oldest", 32'(pc_value), 32'h0024);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("unf_seq_pc", 32'(pc_value), 32'h0028);
        // reset mid-operation wins over a return
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 16'h0700, 1, 0);
        chk("count3", 32'(ras_count), 32'h3);
        step(1, 0, 0, 0, 1, 16'h0900, 1, 1);
        chk("rst_mid_pc", 32'(pc_value), 32'h0100);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0, 16'($urandom),
                 $urandom_range(0, 2) == 0,
                 ($urandom_range(0, 7) == 0) ? 16'hFFFC : 16'($urandom),
                 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program counter for the MIPS core fetch stage. It is the successor to the plain load-only program_counter and adds the following features:
- sequential increment
- stall
- branch and jump redirects with fixed priority
- a RAS_DEPTH-entry return-address stack (RAS) for call/return

It drives the instruction-memory address and exposes the combinational next PC for prefetch.

Parameters:
- PC_W, 16, PC width in bits; all address arithmetic is modulo 2^PC_W.
- PC_INC, 4, sequential increment (byte-addressed 32-bit instructions).
- RESET_VECTOR, 16'h0000, PC value loaded on reset; truncated to PC_W.
- RAS_DEPTH, 4, number of return-stack entries; must be >= 1.

Ports:
- clk_i, in, 1, clock; all state updates on the rising edge.
- rst_i, in, 1, synchronous active-high reset.
- stall_i, in, 1, hold the PC and RAS this cycle.
- branch_taken_i, in, 1, conditional branch resolved taken.
- branch_target_i, in, PC_W, branch destination.
- jump_i, in, 1, unconditional jump.
- jump_target_i, in, PC_W, jump destination.
- call_i, in, 1, qualifies jump_i as a call (push return address).
- ret_i, in, 1, return: the next PC is popped from the RAS.
- pc_value_o, out, PC_W, current PC (registered).
- pc_next_o, out, PC_W, value pc_value_o takes at the next edge (combinational).
- ras_count_o, out, $clog2(RAS_DEPTH+1), number of valid RAS entries.
- ras_empty_o, out, 1, ras_count_o == 0.
- ras_full_o, out, 1, ras_count_o == RAS_DEPTH.
- ras_overflow_o, out, 1, sticky: a push occurred while the stack was full.
- ras_underflow_o, out, 1, sticky: a pop was attempted while the stack was empty.

Behaviour:
- Reset: on any edge with rst_i=1:
  - pc_value_o=RESET_VECTOR
  - RAS emptied (count 0, pointer 0)
  - ras_overflow_o=0, ras_underflow_o=0
  - rst_i overrides all other inputs, including mid-stall and mid-call.
- Latency: one cycle. A request sampled at edge N is visible on pc_value_o after edge N; pc_next_o reflects it combinationally in the same cycle.
- Stall: stall_i=1 ->
  - pc_next_o=pc_value_o
  - RAS, count and sticky flags unchanged
  - all redirect/call/ret inputs ignored, with no side effects.
- Priority when not stalled (highest first):
  1. ret_i, RAS non-empty: next = top of stack; pop; count-1.
  2. ret_i, RAS empty: next = pc_value_o+PC_INC; ras_underflow_o<=1; no pop.
  3. jump_i: next = jump_target_i. If call_i=1, push pc_value_o+PC_INC.
  4. branch_taken_i: next = branch_target_i.
  5. Otherwise: next = pc_value_o+PC_INC.
- Simultaneous events:
  - ret_i with jump_i & call_i: ret wins, no push (a push and a pop never occur in the same cycle).
  - jump_i with branch_taken_i: jump wins.
  - call_i without jump_i: ignored.
- Push when full:
  - the entry is written into a circular buffer, overwriting the oldest entry
  - count stays RAS_DEPTH
  - ras_overflow_o<=1
  - later pops return the newest RAS_DEPTH addresses in LIFO order.
- Arithmetic: PC+PC_INC wraps modulo 2^PC_W (16'hFFFC+4 -> 16'h0000). Targets are used unmodified; no alignment check.
- Sticky flags clear only on reset.
- ras_empty_o and ras_full_o are derived from the registered count and are valid in the reset cycle.

Test Plan:
- Reset/sequential (PC_INC=4, RESET_VECTOR=16'h0100): hold rst_i 2 cycles, release, 3 idle cycles -> pc_value_o 0100, 0104, 0108, 010C; ras_empty_o=1; flags 0.
- Wrap and stall: load 16'hFFF8 via jump, 2 idle cycles -> FFFC, 0000. Then stall_i=1 for 3 cycles with jump_i=1 asserted -> PC holds 0000 and no jump is taken.
- Priority: in one cycle at PC=0200, assert branch_taken_i (0300), jump_i (0400) and ret_i with empty RAS -> PC=0204, ras_underflow_o=1. Next cycle branch+jump -> 0400.
- Call/return: at PC=0100 assert jump_i+call_i to 0500; advance 2 cycles; assert ret_i -> PC 0500, 0504, 0508, then 0104; ras_count_o goes 1 then 0.
- Overflow (RAS_DEPTH=4): 5 nested calls from PCs 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_overflow_o=1, count 4. Then 5 rets -> PCs 0x54, 0x44, 0x34, 0x24, then sequential with ras_underflow_o=1.
- Reset mid-operation: with count 3 and both flags set, pulse rst_i for 1 cycle together with ret_i -> PC=RESET_VECTOR, count 0, flags 0, no pop.
